echo_request_arbiter: RTL and testbench

- Shares one echo datapath (say request port plus heard indication port) among NREQ independent requesters.
- Each requester has a one-entry registered request slot. Occupied slots are issued to the echo in round-robin order.
- The source index of every issued request is pushed into an in-order tag FIFO. Each returning heard indication is routed back to the requester at the FIFO head.

---
 rtl/echo_arb_pkg.sv | 17 +
 rtl/echo_arb_tag_fifo.sv | 49 ++++
 rtl/echo_request_arbiter.sv | 153 +++++++++++++++
 tb/tb_echo_request_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_arb_pkg.sv
// Shared types and helpers for the echo request arbiter.
package echo_arb_pkg;

  localparam int unsigned ECHO_DW = 32;

  // Bits needed to name one of nreq requesters (at least one bit).
  function automatic int unsigned tag_width(input int unsigned nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  // One say/heard payload.
  typedef struct packed {
    logic [ECHO_DW-1:0] meth;
    logic [ECHO_DW-1:0] v;
  } echo_req_t;

endpackage

// File: rtl/echo_arb_tag_fifo.sv
// In-order FIFO of requester tags for issued-but-unanswered echo requests.
module echo_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/echo_request_arbiter.sv
// Round-robin arbiter sharing one echo say/heard datapath among NREQ requesters.
// Optional per-requester grant counters: define ECHO_ARB_STATS_EN.
module echo_request_arbiter
  import echo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = ECHO_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
`ifdef ECHO_ARB_STATS_EN
  output logic [NREQ*16-1:0]   grant_count,
`endif
  input  logic [NREQ-1:0]      req_say_ena,
  input  logic [NREQ*DW-1:0]   req_say_meth,
  input  logic [NREQ*DW-1:0]   req_say_v,
  output logic [NREQ-1:0]      req_say_rdy,
  output logic                 echo_say_ena,
  output logic [DW-1:0]        echo_say_meth,
  output logic [DW-1:0]        echo_say_v,
  input  logic                 echo_say_rdy,
  input  logic                 echo_heard_ena,
  input  logic [DW-1:0]        echo_heard_meth,
  input  logic [DW-1:0]        echo_heard_v,
  output logic                 echo_heard_rdy,
  output logic [NREQ-1:0]      ind_heard_ena,
  output logic [DW-1:0]        ind_heard_meth,
  output logic [DW-1:0]        ind_heard_v,
  input  logic [NREQ-1:0]      ind_heard_rdy
);

  localparam int unsigned TW = tag_width(NREQ);

  logic [NREQ-1:0] slot_valid;
  logic [DW-1:0]   slot_meth [NREQ];
  logic [DW-1:0]   slot_v    [NREQ];
  logic [TW-1:0]   last;
  logic [TW-1:0]   winner;
  logic            found;
  int unsigned     idx;
  logic            can_issue;
  logic [NREQ-1:0] accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic [TW-1:0]   fifo_head;
  logic            pop;

  assign accept      = req_say_ena & ~slot_valid;
  assign req_say_rdy = ~slot_valid;
  assign can_issue   = found && echo_say_rdy && !fifo_full;
  assign pop         = echo_heard_ena && echo_heard_rdy;

  // Request slots: capture on accept, release on issue.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_valid <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        slot_meth[i] <= '0;
        slot_v[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_meth[i]  <= req_say_meth[i*DW +: DW];
          slot_v[i]     <= req_say_v[i*DW +: DW];
        end else if (can_issue && (winner == TW'(i))) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer: last granted requester.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last <= TW'(NREQ - 1);
    end else if (can_issue) begin
      last <= winner;
    end
  end

  // Winner search: first valid slot after last, wrapping at NREQ-1.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && slot_valid[TW'(idx)]) begin
        winner = TW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Issue datapath: winner payload while issuing, zero otherwise.
  always_comb begin
    echo_say_ena  = can_issue;
    echo_say_meth = '0;
    echo_say_v    = '0;
    if (can_issue) begin
      echo_say_meth = slot_meth[winner];
      echo_say_v    = slot_v[winner];
    end
  end

  echo_arb_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (can_issue),
    .din   (winner),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Response routing to the requester owning the oldest outstanding tag.
  always_comb begin
    echo_heard_rdy = !fifo_empty && ind_heard_rdy[fifo_head];
    ind_heard_ena  = '0;
    if (echo_heard_ena && !fifo_empty) begin
      ind_heard_ena[fifo_head] = 1'b1;
    end
    ind_heard_meth = echo_heard_meth;
    ind_heard_v    = echo_heard_v;
  end

`ifdef ECHO_ARB_STATS_EN
  logic [15:0] gcnt [NREQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NREQ); i++) gcnt[i] <= '0;
    end else if (can_issue && (gcnt[winner] != 16'hFFFF)) begin
      gcnt[winner] <= gcnt[winner] + 16'd1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < int'(NREQ); i++) grant_count[i*16 +: 16] = gcnt[i];
  end
`endif

endmodule

// File: tb/tb_echo_request_arbiter.sv
// Self-checking bench for echo_request_arbiter (NREQ=4, DW=32, DEPTH=4).
module tb_echo_request_arbiter;
  import echo_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [NREQ-1:0]     req_say_ena;
  logic [NREQ*DW-1:0]  req_say_meth;
  logic [NREQ*DW-1:0]  req_say_v;
  logic [NREQ-1:0]     req_say_rdy;
  logic                echo_say_ena;
  logic [DW-1:0]       echo_say_meth;
  logic [DW-1:0]       echo_say_v;
  logic                echo_say_rdy;
  logic                echo_heard_ena;
  logic [DW-1:0]       echo_heard_meth;
  logic [DW-1:0]       echo_heard_v;
  logic                echo_heard_rdy;
  logic [NREQ-1:0]     ind_heard_ena;
  logic [DW-1:0]       ind_heard_meth;
  logic [DW-1:0]       ind_heard_v;
  logic [NREQ-1:0]     ind_heard_rdy;
`ifdef ECHO_ARB_STATS_EN
  logic [NREQ*16-1:0]  grant_count;
`endif

  echo_request_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
`ifdef ECHO_ARB_STATS_EN
    .grant_count     (grant_count),
`endif
    .req_say_ena     (req_say_ena),
    .req_say_meth    (req_say_meth),
    .req_say_v       (req_say_v),
    .req_say_rdy     (req_say_rdy),
    .echo_say_ena    (echo_say_ena),
    .echo_say_meth   (echo_say_meth),
    .echo_say_v      (echo_say_v),
    .echo_say_rdy    (echo_say_rdy),
    .echo_heard_ena  (echo_heard_ena),
    .echo_heard_meth (echo_heard_meth),
    .echo_heard_v    (echo_heard_v),
    .echo_heard_rdy  (echo_heard_rdy),
    .ind_heard_ena   (ind_heard_ena),
    .ind_heard_meth  (ind_heard_meth),
    .ind_heard_v     (ind_heard_v),
    .ind_heard_rdy   (ind_heard_rdy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 1'b0;
  logic [3:0]  m_valid;
  echo_req_t   m_slot [NREQ];
  int          m_last;
  int          m_tags [$];
  int          m_gc   [NREQ];
  int          issue_log [$];

  int          w;
  bit          iss;
  bit          hrdy;
  logic [3:0]  e_ind;
  logic [3:0]  e_rdy;
  logic [3:0]  old_valid;

  // Compare DUT against the model, then advance the model across the coming edge.
  always @(negedge CLK) begin
    iss = 1'b0;
    hrdy = 1'b0;
    w = -1;
    if (m_init) begin
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && m_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      iss  = (w >= 0) && echo_say_rdy && (m_tags.size() < DEPTH);
      hrdy = (m_tags.size() > 0) && ind_heard_rdy[m_tags[0]];
      e_ind = 4'b0000;
      if (m_tags.size() > 0 && echo_heard_ena) e_ind[m_tags[0]] = 1'b1;
      e_rdy = ~m_valid;
      chk("m_req_rdy", req_say_rdy, e_rdy);
      chk("m_say_ena", echo_say_ena, iss);
      if (iss) begin
        chk("m_say_meth", echo_say_meth, m_slot[w].meth);
        chk("m_say_v", echo_say_v, m_slot[w].v);
      end
      chk("m_heard_rdy", echo_heard_rdy, hrdy);
      chk("m_ind_ena", ind_heard_ena, e_ind);
      if (echo_heard_ena) begin
        chk("m_ind_meth", ind_heard_meth, echo_heard_meth);
        chk("m_ind_v", ind_heard_v, echo_heard_v);
      end
`ifdef ECHO_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
        chk($sformatf("m_gcnt%0d", i), grant_count[i*16 +: 16], m_gc[i]);
`endif
    end
    if (nRST && echo_say_ena && echo_say_rdy) issue_log.push_back(int'(echo_say_meth));
    if (!nRST) begin
      m_init  = 1'b1;
      m_valid = 4'b0000;
      m_last  = NREQ - 1;
      m_tags.delete();
      for (int i = 0; i < NREQ; i++) m_gc[i] = 0;
    end else if (m_init) begin
      old_valid = m_valid;
      if (echo_heard_ena && hrdy) void'(m_tags.pop_front());
      if (iss) begin
        m_valid[w] = 1'b0;
        m_last = w;
        m_tags.push_back(w);
        if (m_gc[w] < 16'hFFFF) m_gc[w]++;
      end
      for (int i = 0; i < NREQ; i++)
        if (req_say_ena[i] && !old_valid[i]) begin
          m_valid[i] = 1'b1;
          m_slot[i].meth = req_say_meth[i*DW +: DW];
          m_slot[i].v    = req_say_v[i*DW +: DW];
        end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // Load the masked slots with meth = requester index, v = {tag, index}.
  task automatic load(input logic [3:0] mask, input logic [7:0] vtag);
    for (int i = 0; i < NREQ; i++) begin
      req_say_meth[i*DW +: DW] = DW'(i);
      req_say_v[i*DW +: DW]    = {16'h0, vtag, 8'(i)};
    end
    req_say_ena = mask;
    tick();
    req_say_ena = '0;
  endtask

  // Deliver one heard response once the arbiter is ready; check its routing.
  task automatic respond(input string nm, input logic [31:0] m, input logic [31:0] v,
                         input logic [3:0] exp_ind);
    int n;
    n = 0;
    while (!echo_heard_rdy && n < 20) begin
      tick();
      n++;
    end
    if (!echo_heard_rdy) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    echo_heard_ena  = 1'b1;
    echo_heard_meth = m;
    echo_heard_v    = v;
    #1;
    chk({nm, "_ind_ena"}, ind_heard_ena, exp_ind);
    chk({nm, "_ind_meth"}, ind_heard_meth, m);
    chk({nm, "_ind_v"}, ind_heard_v, v);
    tick();
    echo_heard_ena = 1'b0;
  endtask

  task automatic check_log(input string nm, input int exp_q[$]);
    chk({nm, "_len"}, issue_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < issue_log.size(); i++)
      chk($sformatf("%s_%0d", nm, i), issue_log[i], exp_q[i]);
    issue_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int exp_q[$];
    nRST = 1'b0;
    req_say_ena = '0;
    req_say_meth = '0;
    req_say_v = '0;
    echo_say_rdy = 1'b1;
    echo_heard_ena = 1'b0;
    echo_heard_meth = '0;
    echo_heard_v = '0;
    ind_heard_rdy = 4'b1111;
    tick();
    tick();
    // Reset state
    chk("rst_req_rdy", req_say_rdy, 4'b1111);
    chk("rst_say_ena", echo_say_ena, 0);
    chk("rst_heard_rdy", echo_heard_rdy, 0);
    chk("rst_ind_ena", ind_heard_ena, 4'b0000);
    chk("rst_say_meth", echo_say_meth, 0);
    nRST = 1'b1;

    // Single request: accepted, issued next cycle, slot free after issue.
    req_say_meth[31:0] = 32'd1;
    req_say_v[31:0]    = 32'h11;
    req_say_ena = 4'b0001;
    tick();
    req_say_ena = '0;
    chk("t1_say_ena", echo_say_ena, 1);
    chk("t1_say_meth", echo_say_meth, 32'd1);
    chk("t1_say_v", echo_say_v, 32'h11);
    chk("t1_rdy_busy", req_say_rdy[0], 0);
    tick();
    chk("t1_rdy_back", req_say_rdy[0], 1);
    chk("t1_idle", echo_say_ena, 0);
    respond("t1_resp", 32'hA0, 32'hB0, 4'b0001);
    issue_log.delete();

    // All four load together: order 0,1,2,3; then 1 and 3 reload: order 1,3.
    do_reset();
    load(4'b1111, 8'h20);
    repeat (4) tick();
    chk("t2_full_hold", echo_say_ena, 0);
    respond("t2_r0", 32'hC0, 32'hD0, 4'b0001);
    respond("t2_r1", 32'hC1, 32'hD1, 4'b0010);
    respond("t2_r2", 32'hC2, 32'hD2, 4'b0100);
    respond("t2_r3", 32'hC3, 32'hD3, 4'b1000);
    load(4'b1010, 8'h21);
    repeat (3) tick();
    respond("t2_r4", 32'hC4, 32'hD4, 4'b0010);
    respond("t2_r5", 32'hC5, 32'hD5, 4'b1000);
    exp_q = '{0, 1, 2, 3, 1, 3};
    check_log("t2_order", exp_q);
`ifdef ECHO_ARB_STATS_EN
    chk("t2_gcnt", grant_count, 64'h0002_0001_0002_0001);
`endif

    // Echo not ready for 5 cycles with slots full, then resume.
    do_reset();
    echo_say_rdy = 1'b0;
    load(4'b1111, 8'h30);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_ena", echo_say_ena, 0);
      chk("t3_hold_rdy", req_say_rdy, 4'b0000);
      tick();
    end
    echo_say_rdy = 1'b1;
    #1;
    chk("t3_resume_ena", echo_say_ena, 1);
    chk("t3_resume_meth", echo_say_meth, 0);
    repeat (4) tick();

    // Tag FIFO full: a fifth request waits until a response frees an entry.
    load(4'b0001, 8'h40);
    for (int i = 0; i < 3; i++) begin
      chk("t4_pending", echo_say_ena, 0);
      tick();
    end
    respond("t4_r0", 32'hE0, 32'hF0, 4'b0001);
    chk("t4_issue_after_pop", echo_say_ena, 1);
    chk("t4_issue_v", echo_say_v, 32'h4000);
    tick();
    respond("t4_r1", 32'hE1, 32'hF1, 4'b0010);
    respond("t4_r2", 32'hE2, 32'hF2, 4'b0100);
    respond("t4_r3", 32'hE3, 32'hF3, 4'b1000);
    respond("t4_r4", 32'hE4, 32'hF4, 4'b0001);
    exp_q = '{0, 1, 2, 3, 0};
    check_log("t4_order", exp_q);

    // Head owner not ready blocks the response until it becomes ready.
    do_reset();
    ind_heard_rdy = 4'b1011;
    load(4'b0100, 8'h50);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t5_blocked", echo_heard_rdy, 0);
      tick();
    end
    ind_heard_rdy = 4'b1111;
    #1;
    chk("t5_unblocked", echo_heard_rdy, 1);
    respond("t5_r2", 32'h55, 32'h66, 4'b0100);

    // Single active requester: served on every refill.
    for (int k = 0; k < 4; k++) begin
      load(4'b0010, 8'(8'h60 + k));
      chk("t7_issue", echo_say_ena, 1);
      tick();
      respond("t7_resp", 32'h70 + k, 32'h80 + k, 4'b0010);
    end
    issue_log.delete();

    // Reset with outstanding tags and a pending slot discards everything.
    load(4'b0011, 8'h90);
    tick();
    tick();
    echo_say_rdy = 1'b0;
    load(4'b0100, 8'h91);
    chk("t6_pre_heard_rdy", echo_heard_rdy, 1);
    chk("t6_pre_req_rdy", req_say_rdy, 4'b1011);
    echo_say_rdy = 1'b1;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk("t6_req_rdy", req_say_rdy, 4'b1111);
    chk("t6_heard_rdy", echo_heard_rdy, 0);
    chk("t6_say_ena", echo_say_ena, 0);
`ifdef ECHO_ARB_STATS_EN
    chk("t6_gcnt", grant_count, 64'd0);
`endif
    tick();
    chk("t6_heard_rdy2", echo_heard_rdy, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
